// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants: framing bytes, CRC-32 parameters and
// framer state encodings.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [2:0]  ST_WAIT_IDLE  = 3'd0;
  localparam logic [2:0]  ST_IDLE       = 3'd1;
  localparam logic [2:0]  ST_PREAMBLE   = 3'd2;
  localparam logic [2:0]  ST_DATA       = 3'd3;
  localparam logic [2:0]  ST_DROP       = 3'd4;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wise reflected CRC-32 step, LSB of data first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, and
// streams payload bytes with a fixed 5-cycle latency.
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        eth_clocks_rx,
  input  logic        eth_rst_n,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  input  logic [7:0]  eth_rx_data,
  output logic        source_valid,
  output logic [7:0]  source_data,
  output logic        source_first,
  output logic        source_last,
  output logic        source_error,
  output logic [10:0] frame_len,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] DLY_N   = 11'd5;

  logic [2:0]       state;
  logic [4:0][7:0]  dly;
  logic [10:0]      cnt;
  logic [31:0]      crc, crc_nxt;
  logic             rx_er_q;
  logic             frame_bad;
  logic             emit;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (eth_rx_data),
    .crc_out (crc_nxt)
  );

  // Register holds the pre-edge CRC over every byte including FCS, so a good
  // frame leaves the fixed residue behind.
  assign frame_bad = (crc != CRC32_RESIDUE) | rx_er_q | (cnt < MIN_L) | (cnt > MAX_L);
  assign emit      = (cnt >= DLY_N);

  always_ff @(posedge eth_clocks_rx or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state        <= ST_WAIT_IDLE;
      dly          <= '0;
      cnt          <= '0;
      crc          <= '0;
      rx_er_q      <= 1'b0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_first <= 1'b0;
      source_last  <= 1'b0;
      source_error <= 1'b0;
      frame_len    <= '0;
      stat_good    <= '0;
      stat_bad     <= '0;
    end else begin
      source_valid <= 1'b0;
      source_first <= 1'b0;
      source_last  <= 1'b0;
      source_error <= 1'b0;
      case (state)
        ST_WAIT_IDLE: if (!eth_rx_dv) state <= ST_IDLE;
        ST_IDLE, ST_PREAMBLE: begin
          if (!eth_rx_dv)
            state <= ST_IDLE;
          else if (eth_rx_data == PREAMBLE_BYTE)
            state <= ST_PREAMBLE;
          else if (eth_rx_data == SFD_BYTE) begin
            state   <= ST_DATA;
            cnt     <= '0;
            crc     <= CRC32_INIT;
            rx_er_q <= 1'b0;
          end else
            state <= ST_DROP;
        end
        ST_DROP: if (!eth_rx_dv) state <= ST_IDLE;
        ST_DATA: begin
          if (emit) begin
            source_valid <= 1'b1;
            source_data  <= dly[4];
            source_first <= (cnt == DLY_N);
          end
          if (eth_rx_dv) begin
            dly <= {dly[3:0], eth_rx_data};
            crc <= crc_nxt;
            if (cnt != CNT_MAX) cnt <= cnt + 11'd1;
            if (eth_rx_er) rx_er_q <= 1'b1;
          end else begin
            // Frame end: the four bytes still in d0..d3 are the FCS.
            state <= ST_IDLE;
            if (emit) begin
              source_last  <= 1'b1;
              source_error <= frame_bad;
              frame_len    <= cnt - 11'd4;
            end
            if (frame_bad) begin
              if (stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
            end else begin
              if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
            end
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: good/bad FCS, runt, rx_er, mid-frame
// reset, preamble drop and back-to-back frames.
module tb_gmii_rx_framer;

  logic        eth_clocks_rx = 1'b0;
  logic        eth_rst_n     = 1'b0;
  logic        eth_rx_dv     = 1'b0;
  logic        eth_rx_er     = 1'b0;
  logic [7:0]  eth_rx_data   = 8'h00;
  logic        source_valid, source_first, source_last, source_error;
  logic [7:0]  source_data;
  logic [10:0] frame_len;
  logic [15:0] stat_good, stat_bad;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int drive_cyc = 0;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .eth_clocks_rx (eth_clocks_rx),
    .eth_rst_n     (eth_rst_n),
    .eth_rx_dv     (eth_rx_dv),
    .eth_rx_er     (eth_rx_er),
    .eth_rx_data   (eth_rx_data),
    .source_valid  (source_valid),
    .source_data   (source_data),
    .source_first  (source_first),
    .source_last   (source_last),
    .source_error  (source_error),
    .frame_len     (frame_len),
    .stat_good     (stat_good),
    .stat_bad      (stat_bad)
  );

  always #4 eth_clocks_rx = ~eth_clocks_rx;
  always @(posedge eth_clocks_rx) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge.
  logic [7:0] cap_data[$];
  bit         cap_first[$];
  int         first_cyc[$];
  int         last_pos[$];
  bit         last_err[$];
  int         last_len[$];

  always @(negedge eth_clocks_rx) begin
    if (source_valid) begin
      cap_data.push_back(source_data);
      cap_first.push_back(source_first);
      if (source_first) first_cyc.push_back(cyc);
      if (source_last) begin
        last_pos.push_back(cap_data.size() - 1);
        last_err.push_back(source_error);
        last_len.push_back(int'(frame_len));
      end
    end
  end

  logic [7:0] frm[$];

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge eth_clocks_rx); #1;
    eth_rx_dv = dv; eth_rx_data = d; eth_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic build_arp();
    logic [7:0] arp [42] = '{
      8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF, 8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,
      8'h08,8'h06, 8'h00,8'h01, 8'h08,8'h00, 8'h06,8'h04, 8'h00,8'h01,
      8'h00,8'h11,8'h22,8'h33,8'h44,8'h55, 8'hC0,8'hA8,8'h01,8'h01,
      8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'hC0,8'hA8,8'h01,8'h02};
    frm.delete();
    foreach (arp[i]) frm.push_back(arp[i]);
    repeat (18) frm.push_back(8'h00);
  endtask

  function automatic logic [31:0] calc_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Preamble, SFD, frm, FCS (LSB byte first), then one dv=0 cycle.
  task automatic send_frame(input int npre, input bit bad_fcs, input int er_idx);
    logic [31:0] f;
    f = calc_fcs();
    if (bad_fcs) f[0] = ~f[0];
    repeat (npre) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    foreach (frm[i]) begin
      drive(1'b1, frm[i], (i == er_idx));
      if (i == 0) drive_cyc = cyc;
    end
    for (int k = 0; k < 4; k++) drive(1'b1, f[8*k +: 8], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    eth_rst_n = 1'b0;
    #2;
    n_chk++;
    if ({source_valid, source_first, source_last, source_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {source_valid, source_first, source_last, source_error});
    end
    n_chk++;
    if ({source_data, frame_len, stat_good, stat_bad} !== 51'd0) begin
      n_fail++; $display("FAIL reset_values: data=%h len=%0d good=%0d bad=%0d want all 0", source_data, frame_len, stat_good, stat_bad);
    end
    idle(3);
    eth_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int b0 = cap_data.size(), l0 = last_pos.size(), f0 = first_cyc.size();
    build_arp();
    send_frame(7, 1'b0, -1);
    idle(8);
    n_chk++;
    if (cap_data.size() - b0 != 60) begin
      n_fail++; $display("FAIL good_count: got %0d bytes want 60", cap_data.size() - b0);
    end
    for (int i = 0; i < 60 && b0 + i < cap_data.size(); i++) begin
      n_chk++;
      if (cap_data[b0+i] !== frm[i] || cap_first[b0+i] !== (i == 0)) begin
        n_fail++; $display("FAIL good_byte[%0d]: got %h first=%0b want %h first=%0b", i, cap_data[b0+i], cap_first[b0+i], frm[i], (i == 0));
      end
    end
    n_chk++;
    if (first_cyc.size() - f0 != 1) begin
      n_fail++; $display("FAIL good_first_count: got %0d want 1", first_cyc.size() - f0);
    end else if (first_cyc[f0] - (drive_cyc + 1) != 5) begin
      n_fail++; $display("FAIL good_latency: got %0d cycles want 5", first_cyc[f0] - (drive_cyc + 1));
    end
    n_chk++;
    if (last_pos.size() - l0 != 1) begin
      n_fail++; $display("FAIL good_last_count: got %0d want 1", last_pos.size() - l0);
    end else if (last_pos[l0] != b0 + 59 || last_err[l0] !== 1'b0 || last_len[l0] != 60) begin
      n_fail++; $display("FAIL good_last: pos=%0d err=%0b len=%0d want pos=%0d err=0 len=60", last_pos[l0] - b0, last_err[l0], last_len[l0], 59);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd0) begin
      n_fail++; $display("FAIL good_stats: good=%0d bad=%0d want 1/0", stat_good, stat_bad);
    end
  endtask

  task automatic test_bad_fcs();
    int b0 = cap_data.size(), l0 = last_pos.size();
    build_arp();
    send_frame(7, 1'b1, -1);
    idle(8);
    n_chk++;
    if (cap_data.size() - b0 != 60 || last_pos.size() - l0 != 1) begin
      n_fail++; $display("FAIL badfcs_count: got %0d bytes %0d lasts want 60/1", cap_data.size() - b0, last_pos.size() - l0);
    end else if (last_err[l0] !== 1'b1 || last_len[l0] != 60) begin
      n_fail++; $display("FAIL badfcs_last: err=%0b len=%0d want 1/60", last_err[l0], last_len[l0]);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd1) begin
      n_fail++; $display("FAIL badfcs_stats: good=%0d bad=%0d want 1/1", stat_good, stat_bad);
    end
  endtask

  task automatic test_runt();
    int b0 = cap_data.size();
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    idle(8);
    n_chk++;
    if (cap_data.size() != b0) begin
      n_fail++; $display("FAIL runt_output: got %0d bytes want 0", cap_data.size() - b0);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd2) begin
      n_fail++; $display("FAIL runt_stats: good=%0d bad=%0d want 1/2", stat_good, stat_bad);
    end
  endtask

  task automatic test_rx_er();
    int b0 = cap_data.size(), l0 = last_pos.size();
    build_arp();
    send_frame(7, 1'b0, 30);
    idle(8);
    n_chk++;
    if (cap_data.size() - b0 != 60 || last_pos.size() - l0 != 1) begin
      n_fail++; $display("FAIL rxer_count: got %0d bytes %0d lasts want 60/1", cap_data.size() - b0, last_pos.size() - l0);
    end else if (last_err[l0] !== 1'b1) begin
      n_fail++; $display("FAIL rxer_last: err=%0b want 1", last_err[l0]);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd3) begin
      n_fail++; $display("FAIL rxer_stats: good=%0d bad=%0d want 1/3", stat_good, stat_bad);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] f;
    int b0, l0;
    build_arp();
    f = calc_fcs();
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i <= 20; i++) drive(1'b1, frm[i], 1'b0);
    n_chk++;
    if (source_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_streaming: valid=%0b want 1", source_valid);
    end
    eth_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({source_valid, source_first, source_last, source_error} !== 4'b0000 || stat_good !== 16'd0 || stat_bad !== 16'd0) begin
      n_fail++; $display("FAIL midrst_async: flags=%b good=%0d bad=%0d want 0000/0/0", {source_valid, source_first, source_last, source_error}, stat_good, stat_bad);
    end
    b0 = cap_data.size();
    for (int i = 21; i < 60; i++) begin
      drive(1'b1, frm[i], 1'b0);
      if (i == 24) eth_rst_n = 1'b1;
    end
    for (int k = 0; k < 4; k++) drive(1'b1, f[8*k +: 8], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    n_chk++;
    if (cap_data.size() != b0) begin
      n_fail++; $display("FAIL midrst_tail: got %0d bytes want 0", cap_data.size() - b0);
    end
    l0 = last_pos.size();
    send_frame(7, 1'b0, -1);
    idle(8);
    n_chk++;
    if (cap_data.size() - b0 != 60 || last_pos.size() - l0 != 1) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d bytes %0d lasts want 60/1", cap_data.size() - b0, last_pos.size() - l0);
    end else if (last_err[l0] !== 1'b0 || cap_data[b0] !== 8'hFF || cap_first[b0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_next: err=%0b first_byte=%h first=%0b want 0/ff/1", last_err[l0], cap_data[b0], cap_first[b0]);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd0) begin
      n_fail++; $display("FAIL midrst_stats: good=%0d bad=%0d want 1/0", stat_good, stat_bad);
    end
  endtask

  task automatic test_drop();
    logic [31:0] f;
    logic [7:0] pre [6] = '{8'h55, 8'h55, 8'h54, 8'h55, 8'h55, 8'hD5};
    int b0 = cap_data.size();
    build_arp();
    f = calc_fcs();
    foreach (pre[i]) drive(1'b1, pre[i], 1'b0);
    foreach (frm[i]) drive(1'b1, frm[i], 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, f[8*k +: 8], 1'b0);
    idle(8);
    n_chk++;
    if (cap_data.size() != b0) begin
      n_fail++; $display("FAIL drop_output: got %0d bytes want 0", cap_data.size() - b0);
    end
    n_chk++;
    if (stat_good !== 16'd1 || stat_bad !== 16'd0) begin
      n_fail++; $display("FAIL drop_stats: good=%0d bad=%0d want 1/0", stat_good, stat_bad);
    end
  endtask

  task automatic test_back_to_back();
    int b0, l0;
    eth_rst_n = 1'b0;
    idle(2);
    eth_rst_n = 1'b1;
    idle(2);
    b0 = cap_data.size();
    l0 = last_pos.size();
    build_arp();
    send_frame(7, 1'b0, -1);
    send_frame(2, 1'b0, -1);
    idle(8);
    n_chk++;
    if (cap_data.size() - b0 != 120 || last_pos.size() - l0 != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d bytes %0d lasts want 120/2", cap_data.size() - b0, last_pos.size() - l0);
    end else if (last_err[l0] !== 1'b0 || last_err[l0+1] !== 1'b0 || last_len[l0+1] != 60 || cap_first[b0+60] !== 1'b1 || last_pos[l0+1] != b0 + 119) begin
      n_fail++; $display("FAIL b2b_frames: err=%0b/%0b len2=%0d first2=%0b want 0/0/60/1", last_err[l0], last_err[l0+1], last_len[l0+1], cap_first[b0+60]);
    end
    n_chk++;
    if (stat_good !== 16'd2 || stat_bad !== 16'd0) begin
      n_fail++; $display("FAIL b2b_stats: good=%0d bad=%0d want 2/0", stat_good, stat_bad);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_rx_er();
    test_mid_reset();
    test_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
